// File: rtl/framing_buffer.sv
// framing_buffer: slices a continuous sample stream into overlapping frames.
// History lives in a FRAME_LEN-deep ring. Each frame is replayed through a
// two-stage read pipeline (synchronous RAM read, then output register).
// The pipeline prefetches at most one sample ahead, so backpressure on
// do_rdy never skips or duplicates a sample.
module framing_buffer #(
  parameter int DATA_BW    = 14,
  parameter int FRAME_LEN  = 1024,
  parameter int HOP_LEN    = 256,
  parameter int NUM_FRAMES = 89,
  localparam int SIDX_BW   = $clog2(FRAME_LEN),
  localparam int FIDX_BW   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               di_en,
  input  logic [DATA_BW-1:0] data_i,
  output logic               di_rdy,
  output logic               do_en,
  output logic [DATA_BW-1:0] data_o,
  input  logic               do_rdy,
  output logic [SIDX_BW-1:0] sample_idx,
  output logic [FIDX_BW-1:0] frame_idx,
  output logic               frame_first,
  output logic               frame_last,
  output logic               busy,
  output logic               done
);

  localparam int CNT_BW = $clog2(FRAME_LEN + 1);
  localparam int EXT_BW = SIDX_BW + 1;
  localparam logic [SIDX_BW-1:0] LAST_IDX   = SIDX_BW'(FRAME_LEN - 1);
  localparam logic [CNT_BW-1:0]  FULL_CNT   = CNT_BW'(FRAME_LEN);
  localparam logic [CNT_BW-1:0]  HOP_CNT    = CNT_BW'(HOP_LEN);
  localparam logic [FIDX_BW-1:0] LAST_FRAME = FIDX_BW'(NUM_FRAMES - 1);
  localparam logic [EXT_BW-1:0]  HOP_EXT    = EXT_BW'(HOP_LEN);
  localparam logic [EXT_BW-1:0]  FLEN_EXT   = EXT_BW'(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Ring pointer increment, wrapping at FRAME_LEN (works for any length).
  function automatic logic [SIDX_BW-1:0] ptr_inc(input logic [SIDX_BW-1:0] p);
    logic [SIDX_BW-1:0] r;
    if (p == LAST_IDX) r = {SIDX_BW{1'b0}};
    else               r = p + SIDX_BW'(1'b1);
    return r;
  endfunction

  // Frame base advance by HOP_LEN, compare-and-subtract modulo FRAME_LEN.
  function automatic logic [SIDX_BW-1:0] ptr_add_hop(input logic [SIDX_BW-1:0] p);
    logic [EXT_BW-1:0] s;
    s = {1'b0, p} + HOP_EXT;
    if (s >= FLEN_EXT) s = s - FLEN_EXT;
    else               s = s;
    return s[SIDX_BW-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [CNT_BW-1:0]  need_q, need_d;
  logic [SIDX_BW-1:0] wr_ptr_q, wr_ptr_d;
  logic [SIDX_BW-1:0] base_q, base_d;
  logic [SIDX_BW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BW-1:0]  rd_k_q, rd_k_d;
  logic [FIDX_BW-1:0] frame_idx_q, frame_idx_d;
  logic               s1_valid_q, s1_valid_d;
  logic [SIDX_BW-1:0] s1_idx_q, s1_idx_d;
  logic               do_en_q, do_en_d;
  logic [DATA_BW-1:0] data_o_q, data_o_d;
  logic [SIDX_BW-1:0] sample_idx_q, sample_idx_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               di_rdy_q, di_rdy_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [DATA_BW-1:0] ring_q [FRAME_LEN];
  logic [DATA_BW-1:0] ram_rd_q;

  logic in_acc_s, out_acc_s, out_ready_s, s1_adv_s, s1_free_s;
  logic wr_en_s, rd_en_s;

  assign in_acc_s    = di_en & di_rdy_q;
  assign out_acc_s   = do_en_q & do_rdy;
  assign out_ready_s = ~do_en_q | do_rdy;
  assign s1_adv_s    = s1_valid_q & out_ready_s;
  assign s1_free_s   = ~s1_valid_q | out_ready_s;

  // Control FSM: fill/emit sequencing, pointers, counters and read issue.
  always_comb begin
    state_d     = state_q;
    need_d      = need_q;
    wr_ptr_d    = wr_ptr_q;
    base_d      = base_q;
    rd_ptr_d    = rd_ptr_q;
    rd_k_d      = rd_k_q;
    frame_idx_d = frame_idx_q;
    wr_en_s     = 1'b0;
    rd_en_s     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_FILL;
          need_d      = FULL_CNT;
          wr_ptr_d    = {SIDX_BW{1'b0}};
          base_d      = {SIDX_BW{1'b0}};
          rd_k_d      = {CNT_BW{1'b0}};
          frame_idx_d = {FIDX_BW{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_FILL: begin
        if (in_acc_s) begin
          wr_en_s  = 1'b1;
          wr_ptr_d = ptr_inc(wr_ptr_q);
          need_d   = need_q - CNT_BW'(1'b1);
          if (need_q == CNT_BW'(1'b1)) begin
            state_d  = ST_EMIT;
            rd_ptr_d = base_q;
            rd_k_d   = {CNT_BW{1'b0}};
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_EMIT: begin
        if ((rd_k_q < FULL_CNT) && s1_free_s) begin
          rd_en_s  = 1'b1;
          rd_ptr_d = ptr_inc(rd_ptr_q);
          rd_k_d   = rd_k_q + CNT_BW'(1'b1);
        end else begin
          rd_en_s = 1'b0;
        end
        if (out_acc_s && last_q) begin
          rd_k_d = {CNT_BW{1'b0}};
          if (frame_idx_q == LAST_FRAME) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_FILL;
            base_d      = ptr_add_hop(base_q);
            frame_idx_d = frame_idx_q + FIDX_BW'(1'b1);
            need_d      = HOP_CNT;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read pipeline: RAM output stage feeds the held output register.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_idx_d     = s1_idx_q;
    do_en_d      = do_en_q;
    data_o_d     = data_o_q;
    sample_idx_d = sample_idx_q;
    first_d      = first_q;
    last_d       = last_q;
    if (s1_adv_s) begin
      do_en_d      = 1'b1;
      data_o_d     = ram_rd_q;
      sample_idx_d = s1_idx_q;
      first_d      = (s1_idx_q == {SIDX_BW{1'b0}});
      last_d       = (s1_idx_q == LAST_IDX);
    end else if (out_acc_s) begin
      do_en_d = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      do_en_d = do_en_q;
    end
    if (rd_en_s) begin
      s1_valid_d = 1'b1;
      s1_idx_d   = SIDX_BW'(rd_k_q);
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Status outputs registered from the next state so they align with it.
  always_comb begin
    di_rdy_d = (state_d == ST_FILL);
    busy_d   = (state_d == ST_FILL) || (state_d == ST_EMIT);
    done_d   = (state_d == ST_DONE);
  end

  // All control and output registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      need_q       <= {CNT_BW{1'b0}};
      wr_ptr_q     <= {SIDX_BW{1'b0}};
      base_q       <= {SIDX_BW{1'b0}};
      rd_ptr_q     <= {SIDX_BW{1'b0}};
      rd_k_q       <= {CNT_BW{1'b0}};
      frame_idx_q  <= {FIDX_BW{1'b0}};
      s1_valid_q   <= 1'b0;
      s1_idx_q     <= {SIDX_BW{1'b0}};
      do_en_q      <= 1'b0;
      data_o_q     <= {DATA_BW{1'b0}};
      sample_idx_q <= {SIDX_BW{1'b0}};
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      di_rdy_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      need_q       <= need_d;
      wr_ptr_q     <= wr_ptr_d;
      base_q       <= base_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_k_q       <= rd_k_d;
      frame_idx_q  <= frame_idx_d;
      s1_valid_q   <= s1_valid_d;
      s1_idx_q     <= s1_idx_d;
      do_en_q      <= do_en_d;
      data_o_q     <= data_o_d;
      sample_idx_q <= sample_idx_d;
      first_q      <= first_d;
      last_q       <= last_d;
      di_rdy_q     <= di_rdy_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Sample ring with synchronous write and registered synchronous read.
  always_ff @(posedge clk) begin
    if (wr_en_s) ring_q[wr_ptr_q] <= data_i;
    if (rd_en_s) ram_rd_q <= ring_q[rd_ptr_q];
  end

  assign di_rdy      = di_rdy_q;
  assign do_en       = do_en_q;
  assign data_o      = data_o_q;
  assign sample_idx  = sample_idx_q;
  assign frame_idx   = frame_idx_q;
  assign frame_first = first_q;
  assign frame_last  = last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/framing_buffer.md
Name: framing_buffer

Overview:
- Parametrised successor to the sample/group counter in the log-mel front end.
- Slices a continuous sample stream into overlapping frames of FRAME_LEN samples, advancing HOP_LEN samples per frame, for NUM_FRAMES frames.
- Holds history in a FRAME_LEN-entry ring buffer and replays each frame sample-by-sample with position tags to the windowing/FFT stage.
- Has valid/ready handshakes on both sides.

Parameters:
- DATA_BW, 14, sample width in and out.
- FRAME_LEN, 1024, samples per frame; ring depth; at least 2.
- HOP_LEN, 256, frame advance; 1 <= HOP_LEN <= FRAME_LEN.
- NUM_FRAMES, 89, frames per run; at least 1.
- SIDX_BW, $clog2(FRAME_LEN) (localparam), sample-index width.
- FIDX_BW, $clog2(NUM_FRAMES) min 1 (localparam), frame-index width.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse: begin a run.
- di_en, in, 1, input sample valid.
- data_i, in, DATA_BW, input sample.
- di_rdy, out, 1, block accepts a sample this cycle.
- do_en, out, 1, output sample valid.
- data_o, out, DATA_BW, output sample.
- do_rdy, in, 1, downstream accepts.
- sample_idx, out, SIDX_BW, position of data_o within frame, 0..FRAME_LEN-1.
- frame_idx, out, FIDX_BW, frame number, 0..NUM_FRAMES-1.
- frame_first, out, 1, do_en and sample_idx==0.
- frame_last, out, 1, do_en and sample_idx==FRAME_LEN-1.
- busy, out, 1, state not IDLE/DONE.
- done, out, 1, high in DONE.

Behaviour:
- Reset: state IDLE. All outputs 0: di_rdy, do_en, data_o, sample_idx, frame_idx, frame_first, frame_last, busy, done. Pointers and counters also 0. Ring contents are don't-care. Reset mid-run aborts immediately with no further do_en; a new start is required.
- Input accept = di_en & di_rdy. Output accept = do_en & do_rdy. di_en while di_rdy=0 is ignored.
- IDLE:
  - start -> FILL; need=FRAME_LEN, wr_ptr=0, base=0, frame_idx=0.
- FILL:
  - di_rdy=1.
  - Each accept writes ring[wr_ptr], increments wr_ptr mod FRAME_LEN, decrements need.
  - The accept that makes need 0 -> EMIT. di_rdy drops the next cycle.
- EMIT:
  - di_rdy=0.
  - Reads ring[(base+k) mod FRAME_LEN] for k=0..FRAME_LEN-1.
  - Synchronous-read RAM with a registered output. First do_en at most 2 cycles after entering EMIT.
  - With do_rdy held 1, one sample per cycle with no bubbles.
  - While do_en & !do_rdy, data_o, sample_idx, frame_idx, frame_first and frame_last hold stable. The read pipeline prefetches at most one ahead and never skips or duplicates a sample.
  - On accept of frame_last:
    - If frame_idx==NUM_FRAMES-1 -> DONE.
    - Else base += HOP_LEN mod FRAME_LEN, frame_idx++, need=HOP_LEN -> FILL.
  - do_en drops the cycle after the last accept unless a new frame is already valid (it cannot be, since FILL intervenes).
- Overwrite rule: refill writes start at wr_ptr, which equals the old base. Only the HOP_LEN oldest samples are overwritten. Samples still needed by the next frame are preserved.
- HOP_LEN==FRAME_LEN gives non-overlapping frames, with each refill replacing the whole ring.
- DONE:
  - done=1, di_rdy=0, do_en=0.
  - start -> FILL with state reinitialised as from IDLE.
- start is ignored in FILL/EMIT.
- Indices: sample_idx counts 0..FRAME_LEN-1 and wraps to 0 per frame. frame_idx saturates at NUM_FRAMES-1; no overflow is possible.
- Pointer arithmetic is modulo FRAME_LEN and must be correct for non-power-of-2 FRAME_LEN (compare-and-subtract, not bit truncation).
- Total inputs consumed per run: FRAME_LEN + (NUM_FRAMES-1)*HOP_LEN.

Test Plan:
- FRAME_LEN=8, HOP_LEN=4, NUM_FRAMES=3; start, then feed 1..16 with di_en=1 and do_rdy=1 -> frames out: 1..8, 5..12, 9..16. frame_idx is 0,1,2. frame_first on values 1,5,9; frame_last on 8,12,16. done=1 after value 16 is accepted. di_rdy=0 during every EMIT.
- Same config with do_rdy toggled randomly (about 50%) -> identical sequence and tags. data_o and tags are stable whenever do_en & !do_rdy. No duplicates or drops.
- FRAME_LEN=6, HOP_LEN=6, NUM_FRAMES=2 (non-power-of-2, no overlap); feed 1..12 -> frames 1..6 and 7..12. Pointer wrap is correct.
- FRAME_LEN=5, HOP_LEN=2, NUM_FRAMES=4; feed 1..11 with gaps in di_en -> frames 1..5, 3..7, 5..9, 7..11.
- Assert rst=0 mid-EMIT of frame 1 -> all outputs 0 within the reset cycle and state IDLE. start, then feed 1..16 -> clean run exactly as in the first scenario.
- Pulse start during FILL and EMIT -> no effect. di_en=1 during EMIT and DONE -> not consumed, and the output sequence is unaffected. start in DONE -> a new run with frame_idx=0 and done=0.
